color_sense_classifier: RTL

//  Parametrised TCS3200-style colour front end for the rover. Steps the sensor filter (S2/S3) through

---
 rtl/color_sense_classifier_if.sv | 45 ++++
 rtl/color_sense_classifier.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_sense_classifier_if.sv
// Bus for the colour-sense front end.
// Groups the run control, the raw sensor pin, the TCS3200 select lines and
// every measurement/classification result into one bundle.
//   slave  : seen by color_sense_classifier (takes enable/colorsignal, drives the rest)
//   master : seen by whoever controls and consumes the classifier
// Signals:
//   enable       run measurement rounds continuously while high
//   colorsignal  raw sensor output, asynchronous to the clock
//   S0, S1       frequency-scale select (constant)
//   S2, S3       colour filter select
//   freq_b/g/r/c last completed scaled value per channel
//   num          0 none yet, 1 red, 2 green, 3 blue, 4 clear/undecided
//   round_valid  one-cycle pulse when all four freq_* have updated
//   num_changed  one-cycle pulse when num takes a new value
//   busy         high while the measurement FSM is not idle
interface color_sense_classifier_if #(
    parameter int FREQ_W = 32
);
    logic              enable;
    logic              colorsignal;
    logic              S0;
    logic              S1;
    logic              S2;
    logic              S3;
    logic [FREQ_W-1:0] freq_b;
    logic [FREQ_W-1:0] freq_g;
    logic [FREQ_W-1:0] freq_r;
    logic [FREQ_W-1:0] freq_c;
    logic [2:0]        num;
    logic              round_valid;
    logic              num_changed;
    logic              busy;

    modport slave (
        input  enable, colorsignal,
        output S0, S1, S2, S3, freq_b, freq_g, freq_r, freq_c,
               num, round_valid, num_changed, busy
    );

    modport master (
        output enable, colorsignal,
        input  S0, S1, S2, S3, freq_b, freq_g, freq_r, freq_c,
               num, round_valid, num_changed, busy
    );
endinterface

// File: rtl/color_sense_classifier.sv
// TCS3200-style colour front end.
// Steps the sensor filter through blue, green, red, clear; counts sensor
// rising edges over a fixed gate per channel; scales each count; then picks
// the dominant colour with a margin and a confirmation run before updating num.
// Ports:
//   clock  system clock, all logic on posedge
//   reset  asynchronous, active-high
//   bus    color_sense_classifier_if.slave (control in, select lines and results out)
module color_sense_classifier #(
    parameter int         GATE_CYCLES   = 6250000,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         CNT_W         = 24,
    parameter int         FREQ_W        = 32,
    parameter logic [7:0] SCALE_B       = 8'd30,
    parameter logic [7:0] SCALE_G       = 8'd36,
    parameter logic [7:0] SCALE_R       = 8'd21,
    parameter logic [7:0] SCALE_C       = 8'd12,
    parameter int         MARGIN        = 0,
    parameter int         CONFIRM_N     = 2,
    parameter logic [1:0] FREQ_SCALE    = 2'b10
) (
    input logic clock,
    input logic reset,
    color_sense_classifier_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, CLASSIFY} state_t;
    typedef enum logic [1:0] {CH_B, CH_G, CH_R, CH_C} chan_t;

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (CNT_W + 8 > FREQ_W) ? CNT_W + 8 : FREQ_W;
    localparam int CW   = FREQ_W + 32;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);

    state_t            state;
    chan_t             chan;
    logic [1:0]        filt;
    logic [TW-1:0]     timer;
    logic [CNT_W-1:0]  raw;
    logic [1:0]        sync;
    logic              prev;
    logic              rise;
    logic [FREQ_W-1:0] freq_b, freq_g, freq_r, freq_c;
    logic [2:0]        num;
    logic              round_valid, num_changed, busy;
    logic [3:0]        run;
    logic [2:0]        prev_cls;

    logic [7:0]        scale_sel;
    logic [CNT_W+7:0]  product;
    logic [PW-1:0]     product_ext;
    logic [FREQ_W-1:0] scaled;
    logic [2:0]        cls;
    logic [3:0]        run_next;
    logic              confirmed;

    // Filter code on {S2,S3} for each channel.
    function automatic logic [1:0] filter_code(input chan_t c);
        case (c)
            CH_B:    return 2'b01;
            CH_G:    return 2'b11;
            CH_R:    return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    // Strict "a beats b by more than MARGIN", widened so b+MARGIN cannot wrap.
    function automatic logic beats(input logic [FREQ_W-1:0] a, input logic [FREQ_W-1:0] b);
        return CW'(a) > (CW'(b) + CW'(MARGIN));
    endfunction

    // A detected edge is the synchronised level going high while its previous sample was low.
    assign rise = sync[1] & ~prev;

    // Scale the raw count of the channel being stored, clamping to the output width.
    always_comb begin
        scale_sel = SCALE_C;
        case (chan)
            CH_B:    scale_sel = SCALE_B;
            CH_G:    scale_sel = SCALE_G;
            CH_R:    scale_sel = SCALE_R;
            default: scale_sel = SCALE_C;
        endcase
        product     = {8'd0, raw} * {{CNT_W{1'b0}}, scale_sel};
        product_ext = PW'(product);
        if (product_ext > PW'({FREQ_W{1'b1}}))
            scaled = '1;
        else
            scaled = product_ext[FREQ_W-1:0];
    end

    // A colour wins only if it strictly beats all three others; ties and a clear win give 4.
    // The run counter tracks how many consecutive rounds produced the same class.
    always_comb begin
        cls = 3'd4;
        if (beats(freq_r, freq_g) && beats(freq_r, freq_b) && beats(freq_r, freq_c))
            cls = 3'd1;
        else if (beats(freq_g, freq_r) && beats(freq_g, freq_b) && beats(freq_g, freq_c))
            cls = 3'd2;
        else if (beats(freq_b, freq_r) && beats(freq_b, freq_g) && beats(freq_b, freq_c))
            cls = 3'd3;
        run_next = 4'd1;
        if (run != 4'd0 && cls == prev_cls)
            run_next = (run == 4'hF) ? run : run + 4'd1;
        confirmed = int'(run_next) >= CONFIRM_N;
    end

    // Two-flop synchroniser plus a history flop for edge detection on the sensor pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], bus.colorsignal};
            prev <= sync[1];
        end
    end

    // Measurement FSM: settle, gate and store per channel, then one classify cycle.
    // All outputs are registered here; the timer counts down to zero in SETTLE and GATE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            chan        <= CH_B;
            filt        <= 2'b01;
            timer       <= '0;
            raw         <= '0;
            freq_b      <= '0;
            freq_g      <= '0;
            freq_r      <= '0;
            freq_c      <= '0;
            num         <= 3'd0;
            round_valid <= 1'b0;
            num_changed <= 1'b0;
            busy        <= 1'b0;
            run         <= 4'd0;
            prev_cls    <= 3'd0;
        end else begin
            round_valid <= 1'b0;
            num_changed <= 1'b0;
            case (state)
                IDLE: begin
                    chan <= CH_B;
                    filt <= 2'b01;
                    if (bus.enable) begin
                        state <= SETTLE;
                        timer <= SETTLE_LOAD;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        state <= GATE;
                        timer <= GATE_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GATE: begin
                    if (rise && raw != {CNT_W{1'b1}})
                        raw <= raw + 1'b1;
                    if (timer == '0)
                        state <= STORE;
                    else
                        timer <= timer - 1'b1;
                end
                STORE: begin
                    raw <= '0;
                    case (chan)
                        CH_B:    freq_b <= scaled;
                        CH_G:    freq_g <= scaled;
                        CH_R:    freq_r <= scaled;
                        default: freq_c <= scaled;
                    endcase
                    if (chan == CH_C) begin
                        state       <= CLASSIFY;
                        round_valid <= 1'b1;
                    end else begin
                        chan  <= chan_t'(chan + 2'd1);
                        filt  <= filter_code(chan_t'(chan + 2'd1));
                        state <= SETTLE;
                        timer <= SETTLE_LOAD;
                    end
                end
                CLASSIFY: begin
                    run      <= run_next;
                    prev_cls <= cls;
                    if (confirmed && cls != num) begin
                        num         <= cls;
                        num_changed <= 1'b1;
                    end
                    chan <= CH_B;
                    filt <= 2'b01;
                    if (bus.enable) begin
                        state <= SETTLE;
                        timer <= SETTLE_LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S0          = FREQ_SCALE[1];
    assign bus.S1          = FREQ_SCALE[0];
    assign bus.S2          = filt[1];
    assign bus.S3          = filt[0];
    assign bus.freq_b      = freq_b;
    assign bus.freq_g      = freq_g;
    assign bus.freq_r      = freq_r;
    assign bus.freq_c      = freq_c;
    assign bus.num         = num;
    assign bus.round_valid = round_valid;
    assign bus.num_changed = num_changed;
    assign bus.busy        = busy;

endmodule
